// File: rtl/instr_loader.sv
// instr_loader: packs a byte stream into 16-bit instruction writes, then releases the core into run.
// Optional INSTR_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the end marker.
module instr_loader #(
   parameter int          ADDR_W   = 8,
   parameter int          DEPTH    = 256,
   parameter logic [15:0] END_WORD = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              soft_clr,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [1:0]        valid,
   output logic [15:0]       instruction,
   output logic [ADDR_W-1:0] instruction_address,
   output logic [ADDR_W:0]   word_count,
   output logic              error
);

   typedef enum logic [2:0] {
      S_HI,
      S_LO,
      S_WRITE,
      S_RUN,
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_ERR
   } state_t;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   state_t      state;
   state_t      state_nx;
   logic        live;
   logic [7:0]  hi_byte;
   logic [15:0] w_in;
   logic        take;
   logic        full;
   logic        is_end;

`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   // live keeps in_ready low for the first cycle after any clear
   always_comb begin
      in_ready = 1'b0;
      if (live) begin
         unique case (state)
            S_HI:    in_ready = 1'b1;
            S_LO:    in_ready = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHK:   in_ready = 1'b1;
`endif
            default: in_ready = 1'b0;
         endcase
      end
   end

   assign take   = in_valid && in_ready;
   assign w_in   = {hi_byte, in_data};
   assign full   = (word_count == FULL_CNT);
   assign is_end = (w_in == END_WORD);
   assign error  = (state == S_ERR);

   always_comb begin
      state_nx = state;
      valid    = 2'b00;
      unique case (state)
         S_HI: begin
            if (take) state_nx = S_LO;
         end
         S_LO: begin
            if (take) begin
               if (is_end) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                  state_nx = S_CHK;
`else
                  state_nx = S_RUN;
`endif
               end else if (full) begin
                  state_nx = S_ERR;
               end else begin
                  state_nx = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            valid    = 2'b01;
            state_nx = S_HI;
         end
         S_RUN: begin
            valid = 2'b11;
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (take) state_nx = (in_data == csum) ? S_RUN : S_ERR;
         end
`endif
         S_ERR: begin
            state_nx = S_ERR;
         end
         default: state_nx = S_HI;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= S_HI;
         live                <= 1'b0;
         hi_byte             <= '0;
         instruction         <= '0;
         instruction_address <= '0;
         word_count          <= '0;
      end else if (soft_clr) begin
         state               <= S_HI;
         live                <= 1'b0;
         hi_byte             <= '0;
         instruction         <= '0;
         instruction_address <= '0;
         word_count          <= '0;
      end else begin
         state <= state_nx;
         live  <= 1'b1;
         if (take && state == S_HI) hi_byte <= in_data;
         // output regs load only for a real write, so they hold otherwise
         if (take && state == S_LO && !is_end && !full) begin
            instruction         <= w_in;
            instruction_address <= word_count[ADDR_W-1:0];
         end
         if (state == S_WRITE) word_count <= word_count + 1'b1;
      end
   end

`ifdef INSTR_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum <= '0;
      end else if (soft_clr) begin
         csum <= '0;
      end else if (take && state != S_CHK) begin
         csum <= csum ^ in_data;
      end
   end
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: table records, directed corner sequences, and random programs
// checked against a stream-level reference model.
module tb_instr_loader;

   logic        clk;
   logic        rst_n;
   logic        soft_clr;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  valid;
   logic [15:0] instruction;
   logic [7:0]  instruction_address;
   logic [8:0]  word_count;
   logic        error;

   instr_loader dut (
      .clk(clk),
      .rst_n(rst_n),
      .soft_clr(soft_clr),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .valid(valid),
      .instruction(instruction),
      .instruction_address(instruction_address),
      .word_count(word_count),
      .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_acc = -10;

   logic [23:0] wr_q[$];
   logic [23:0] exp_q[$];
   logic [15:0] wq[$];
   logic [7:0]  bq[$];
   int          exp_st;
   int          exp_wc;

   typedef struct {
      int          n;
      logic [15:0] w[4];
      logic [1:0]  ev;
      int          ewc;
      logic        eerr;
   } vec_t;

   vec_t vt[4];

   always @(posedge clk) cyc++;

   // Capture every write pulse; it must follow the low-byte accept by one cycle
   always @(negedge clk) begin
      if (rst_n && valid == 2'b01) begin
         wr_q.push_back({instruction_address, instruction});
         total++;
         if (cyc != last_acc || in_ready) begin
            bad++;
            $display("FAIL write_timing: cyc=%0d acc=%0d in_ready=%0b want cyc=acc ready=0",
                     cyc, last_acc, in_ready);
         end
      end
   end

   // Reference: interpret the byte stream word by word
   task automatic model();
      int i;
      int wc;
      logic [7:0] x;
      logic [15:0] w;
      exp_q.delete();
      wc = 0;
      x = 8'h00;
      i = 0;
      exp_st = 0;
      while (i + 1 < bq.size() && exp_st == 0) begin
         w = {bq[i], bq[i+1]};
         x = x ^ bq[i] ^ bq[i+1];
         i += 2;
         if (w == 16'hFFFF) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            if (i < bq.size()) exp_st = (bq[i] == x) ? 1 : 2;
`else
            exp_st = 1;
`endif
         end else if (wc == 256) begin
            exp_st = 2;
         end else begin
            exp_q.push_back({8'(wc), w});
            wc++;
         end
      end
      exp_wc = wc;
   endtask

   task automatic mk_stream();
      logic [7:0] x;
      bq.delete();
      x = 8'h00;
      foreach (wq[k]) begin
         bq.push_back(wq[k][15:8]);
         bq.push_back(wq[k][7:0]);
      end
      bq.push_back(8'hFF);
      bq.push_back(8'hFF);
`ifdef INSTR_LOADER_CHECKSUM_EN
      foreach (bq[k]) x = x ^ bq[k];
      bq.push_back(x);
`endif
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int n;
      if (gap > 0) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         repeat (gap - 1) @(negedge clk);
      end
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         total++;
         bad++;
         $display("FAIL send_timeout: byte=%h in_ready=%0b want 1", b, in_ready);
      end else begin
         @(posedge clk);
         #1 last_acc = cyc;
      end
   endtask

   task automatic send_all(input int gmax);
      foreach (bq[k]) send(bq[k], $urandom_range(0, gmax));
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_prog(input string nm);
      int mm;
      logic [1:0] ev;
      model();
      total++;
      mm = 0;
      if (wr_q.size() != exp_q.size()) mm = 1;
      else foreach (exp_q[k]) if (wr_q[k] != exp_q[k]) mm++;
      if (mm != 0) begin
         bad++;
         $display("FAIL %s_writes: got %0d writes (first %h) want %0d (first %h)", nm,
                  wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 24'h0,
                  exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : 24'h0);
      end
      ev = (exp_st == 1) ? 2'b11 : 2'b00;
      total++;
      if (valid != ev || error != (exp_st == 2) || word_count != 9'(exp_wc)) begin
         bad++;
         $display("FAIL %s_end: valid=%b err=%0b wc=%0d want valid=%b err=%0b wc=%0d", nm,
                  valid, error, word_count, ev, exp_st == 2, exp_wc);
      end
   endtask

   task automatic do_clr();
      @(negedge clk);
      soft_clr = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      soft_clr = 1'b0;
      wr_q.delete();
      total++;
      if (valid != 2'b00 || word_count != 9'd0 || error != 1'b0) begin
         bad++;
         $display("FAIL soft_clr: valid=%b wc=%0d err=%0b want 00 0 0",
                  valid, word_count, error);
      end
   endtask

   task automatic rand_words(input int n);
      logic [15:0] w;
      wq.delete();
      for (int k = 0; k < n; k++) begin
         w = 16'($urandom);
         if (w == 16'hFFFF) w = 16'h1234;
         wq.push_back(w);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      soft_clr = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;

      vt[0] = '{3, '{16'h3001, 16'h3102, 16'h2321, 16'h0000}, 2'b11, 3, 1'b0};
      vt[1] = '{0, '{16'h0000, 16'h0000, 16'h0000, 16'h0000}, 2'b11, 0, 1'b0};
      vt[2] = '{1, '{16'h0000, 16'h0000, 16'h0000, 16'h0000}, 2'b11, 1, 1'b0};
      vt[3] = '{4, '{16'hFFFE, 16'h1234, 16'h8000, 16'h00FF}, 2'b11, 4, 1'b0};

      repeat (3) @(negedge clk);
      total++;
      if (valid != 0 || instruction != 0 || instruction_address != 0 ||
          word_count != 0 || error != 0 || in_ready != 0) begin
         bad++;
         $display("FAIL reset_state: v=%b i=%h a=%h wc=%0d e=%0b r=%0b want all 0",
                  valid, instruction, instruction_address, word_count, error, in_ready);
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (in_ready != 1'b0) begin
         bad++;
         $display("FAIL ready_at_release: got %0b want 0", in_ready);
      end
      @(negedge clk);
      total++;
      if (in_ready != 1'b1) begin
         bad++;
         $display("FAIL ready_after_clk: got %0b want 1", in_ready);
      end

      // Table records, each started from a soft clear
      for (int r = 0; r < 4; r++) begin
         do_clr();
         wq.delete();
         for (int k = 0; k < vt[r].n; k++) wq.push_back(vt[r].w[k]);
         mk_stream();
         send_all(r % 2);
         total++;
         if (valid != vt[r].ev || word_count != 9'(vt[r].ewc) || error != vt[r].eerr) begin
            bad++;
            $display("FAIL table_%0d: valid=%b wc=%0d err=%0b want %b %0d %0b", r,
                     valid, word_count, error, vt[r].ev, vt[r].ewc, vt[r].eerr);
         end
         check_prog("table");
      end

      // Full memory then marker is legal
      do_clr();
      rand_words(256);
      mk_stream();
      send_all(0);
      check_prog("full256");
      total++;
      if (wr_q.size() != 256 || wr_q[255][23:16] != 8'd255) begin
         bad++;
         $display("FAIL last_addr: writes=%0d want 256 ending at addr 255", wr_q.size());
      end

      // One word past the end is an overflow
      do_clr();
      rand_words(256);
      wq.push_back(16'h3000);
      bq.delete();
      foreach (wq[k]) begin
         bq.push_back(wq[k][15:8]);
         bq.push_back(wq[k][7:0]);
      end
      send_all(0);
      check_prog("overflow");

      // Async reset in the middle of a word
      do_clr();
      bq = '{8'h30, 8'h01, 8'h31, 8'h02, 8'h30};
      foreach (bq[k]) send(bq[k], 0);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (valid != 0 || instruction != 0 || instruction_address != 0 ||
          word_count != 0 || error != 0 || in_ready != 0) begin
         bad++;
         $display("FAIL async_reset: v=%b i=%h a=%h wc=%0d r=%0b want all 0",
                  valid, instruction, instruction_address, word_count, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wr_q.delete();
      send(8'h30, 0);
      send(8'h05, 0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (wr_q.size() != 1 || wr_q[0] != 24'h003005) begin
         bad++;
         $display("FAIL after_reset_write: n=%0d first=%h want 1 x 003005",
                  wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 24'h0);
      end

`ifdef INSTR_LOADER_CHECKSUM_EN
      do_clr();
      bq = '{8'h30, 8'h01, 8'hFF, 8'hFF, 8'h31};
      send_all(0);
      check_prog("cs_good");
      do_clr();
      bq = '{8'h30, 8'h01, 8'hFF, 8'hFF, 8'h00};
      send_all(1);
      check_prog("cs_bad");
`endif

      // Random programs with random valid gaps
      for (int r = 0; r < 8; r++) begin
         do_clr();
         rand_words($urandom_range(0, 12));
         mk_stream();
         send_all(2);
         check_prog("random");
      end

      do_clr();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
